// File: rtl/icache_req_stage_pkg.sv
// Shared ICache request-stage header: geometry, derived widths and FSM state type.
package icache_req_stage_pkg;

    localparam int PC_WD             = 32;
    localparam int ICACHE_OFFSET_WD  = 4;
    localparam int ICACHE_INDEX_WD   = 7;
    localparam int ICACHE_SRAM_AW    = 6;
    localparam int ICACHE_WAYS       = 2;
    localparam int NGRP              = 2 ** (ICACHE_INDEX_WD - ICACHE_SRAM_AW);
    localparam int IRS_TO_ICS_BUS_WD = PC_WD + ICACHE_WAYS * NGRP;

    typedef enum logic [1:0] {
        IRS_INIT  = 2'd0,
        IRS_RUN   = 2'd1,
        IRS_DRAIN = 2'd2,
        IRS_SWEEP = 2'd3
    } irs_state_e;

endpackage

// File: rtl/icache_grp_decode.sv
// Bank-group decode: sets the WAYS bits belonging to one group; bit w*NGRP+g = way w, group g.
module icache_grp_decode #(
    parameter int WAYS = 2,
    parameter int NGRP = 2,
    parameter int GW   = 1
) (
    input  logic [GW-1:0]        grp,
    output logic [WAYS*NGRP-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int w = 0; w < WAYS; w++) begin
            for (int g = 0; g < NGRP; g++) begin
                mask[w*NGRP+g] = (grp == GW'(g));
            end
        end
    end

endmodule

// File: rtl/icache_req_stage.sv
// ICache lookup-issue stage: issues per-way SRAM reads for accepted fetches, holds the request
// for the compare stage, and sweeps all valid bits after reset and on inv_all.
module icache_req_stage
    import icache_req_stage_pkg::*;
#(
    parameter int PC_WD     = icache_req_stage_pkg::PC_WD,
    parameter int OFFSET_WD = ICACHE_OFFSET_WD,
    parameter int INDEX_WD  = ICACHE_INDEX_WD,
    parameter int SRAM_AW   = ICACHE_SRAM_AW,
    parameter int WAYS      = ICACHE_WAYS,
    localparam int NG       = 2 ** (INDEX_WD - SRAM_AW),
    localparam int NB       = WAYS * NG
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inst_en,
    input  logic [PC_WD-1:0]    inst_addr,
    output logic                inst_ready,
    input  logic                flush,
    input  logic                inv_all,
    input  logic                cmp_allowin,
    output logic                rs_to_cs_valid,
    output logic [PC_WD+NB-1:0] rs_to_cs_bus,
    output logic [NB-1:0]       rden,
    output logic [SRAM_AW-1:0]  raddr,
    output logic [NB-1:0]       inv_we,
    output logic                busy
);

    localparam int GW = (INDEX_WD > SRAM_AW) ? (INDEX_WD - SRAM_AW) : 1;

    irs_state_e          state_q, state_d;
    logic [INDEX_WD-1:0] cnt_q, cnt_d;
    logic                req_valid_q;
    logic [PC_WD-1:0]    addr_q;
    logic [NB-1:0]       rden_q;

    logic [INDEX_WD-1:0] idx;
    logic [GW-1:0]       req_grp, cnt_grp;
    logic [NB-1:0]       req_mask, inv_mask;
    logic                accept;

    assign idx = inst_addr[OFFSET_WD+INDEX_WD-1:OFFSET_WD];

    // With a single bank group the group select collapses to a constant zero.
    if (INDEX_WD > SRAM_AW) begin : g_multi_grp
        assign req_grp = idx[INDEX_WD-1:SRAM_AW];
        assign cnt_grp = cnt_q[INDEX_WD-1:SRAM_AW];
    end else begin : g_single_grp
        assign req_grp = '0;
        assign cnt_grp = '0;
    end

    icache_grp_decode #(.WAYS(WAYS), .NGRP(NG), .GW(GW)) u_req_dec (
        .grp  (req_grp),
        .mask (req_mask)
    );

    icache_grp_decode #(.WAYS(WAYS), .NGRP(NG), .GW(GW)) u_inv_dec (
        .grp  (cnt_grp),
        .mask (inv_mask)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        inst_ready = 1'b0;
        rden       = '1;
        raddr      = idx[SRAM_AW-1:0];
        inv_we     = '0;
        busy       = 1'b0;
        case (state_q)
            IRS_INIT, IRS_SWEEP: begin
                busy   = 1'b1;
                raddr  = cnt_q[SRAM_AW-1:0];
                // No clear strobes while reset is held, even though the state reads INIT.
                inv_we = rst_n ? inv_mask : '0;
                cnt_d  = cnt_q + INDEX_WD'(1);
                if (cnt_q == '1) state_d = IRS_RUN;
            end
            IRS_RUN: begin
                inst_ready = !flush && (!req_valid_q || cmp_allowin);
                if (inst_en && inst_ready) rden = ~req_mask;
                if (inv_all) state_d = (!req_valid_q || flush) ? IRS_SWEEP : IRS_DRAIN;
            end
            IRS_DRAIN: begin
                // inst_ready is low here, so the register empties on handoff or flush.
                if (!req_valid_q || flush || cmp_allowin) state_d = IRS_SWEEP;
            end
            default: state_d = IRS_INIT;
        endcase
    end

    assign accept = inst_en && inst_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IRS_INIT;
            cnt_q       <= '0;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            rden_q      <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (flush) begin
                req_valid_q <= 1'b0;
            end else if (accept) begin
                req_valid_q <= 1'b1;
                addr_q      <= inst_addr;
                rden_q      <= rden;
            end else if (req_valid_q && cmp_allowin) begin
                req_valid_q <= 1'b0;
            end
        end
    end

    assign rs_to_cs_valid = req_valid_q;
    assign rs_to_cs_bus   = {addr_q, ~rden_q};

endmodule

// File: tb/tb_icache_req_stage.sv
// Bench for icache_req_stage: table vectors, hand-written corner sequences and random traffic
// checked against a queue-based behavioural model; a second instance covers the one-group variant.
module tb_icache_req_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_en, flush, inv_all, cmp_allowin;
    logic [31:0] inst_addr;
    logic        inst_ready, rs_to_cs_valid, busy;
    logic [35:0] rs_to_cs_bus;
    logic [3:0]  rden, inv_we;
    logic [5:0]  raddr;

    logic        en4;
    logic [31:0] addr4;
    logic        ready4, valid4, busy4;
    logic [35:0] bus4;
    logic [3:0]  rden4, inv4;
    logic [5:0]  raddr4;

    always #5 clk = ~clk;

    icache_req_stage dut (
        .clk(clk), .rst_n(rst_n), .inst_en(inst_en), .inst_addr(inst_addr),
        .inst_ready(inst_ready), .flush(flush), .inv_all(inv_all), .cmp_allowin(cmp_allowin),
        .rs_to_cs_valid(rs_to_cs_valid), .rs_to_cs_bus(rs_to_cs_bus), .rden(rden),
        .raddr(raddr), .inv_we(inv_we), .busy(busy)
    );

    icache_req_stage #(.INDEX_WD(6), .SRAM_AW(6), .WAYS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .inst_en(en4), .inst_addr(addr4),
        .inst_ready(ready4), .flush(1'b0), .inv_all(1'b0), .cmp_allowin(1'b1),
        .rs_to_cs_valid(valid4), .rs_to_cs_bus(bus4), .rden(rden4),
        .raddr(raddr4), .inv_we(inv4), .busy(busy4)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: sweep cycles remaining, drain flag, and the held request as a queue.
    int          m_left;
    bit          m_drain;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] grp_ways(input int g);
        logic [3:0] m = 4'b0000;
        for (int w = 0; w < 2; w++) m[w*2+g] = 1'b1;
        return m;
    endfunction

    // Called at the falling edge: compares all outputs, then advances the model across the next rising edge.
    task automatic model_step();
        bit         sweeping, held, accept, e_ready;
        logic [3:0] e_rden, e_inv;
        int         n;
        sweeping = (m_left > 0);
        held     = (exp_q.size() != 0);
        accept   = 1'b0;
        e_ready  = 1'b0;
        e_rden   = 4'hF;
        e_inv    = 4'h0;
        if (sweeping) begin
            n     = 128 - m_left;
            e_inv = grp_ways(n / 64);
            check("sweep_raddr", 64'(raddr), 64'(n % 64));
        end else if (!m_drain) begin
            e_ready = !flush && (!held || cmp_allowin);
            accept  = inst_en && e_ready;
            if (accept) begin
                e_rden = ~grp_ways(int'(inst_addr[10]));
                check("issue_raddr", 64'(raddr), 64'(inst_addr[9:4]));
            end
        end
        check("busy", 64'(busy), 64'(sweeping));
        check("inst_ready", 64'(inst_ready), 64'(e_ready));
        check("rden", 64'(rden), 64'(e_rden));
        check("inv_we", 64'(inv_we), 64'(e_inv));
        check("rs_valid", 64'(rs_to_cs_valid), 64'(held));
        if (held) check("rs_bus", 64'(rs_to_cs_bus), 64'({exp_q[0], grp_ways(int'(exp_q[0][10]))}));

        if (sweeping) begin
            m_left--;
        end else if (m_drain) begin
            if (!held || flush || cmp_allowin) begin
                m_drain = 1'b0;
                m_left  = 128;
            end
        end else if (inv_all) begin
            if (!held || flush) m_left = 128;
            else m_drain = 1'b1;
        end
        if (held && (cmp_allowin || flush)) void'(exp_q.pop_front());
        if (flush) exp_q.delete();
        else if (accept) exp_q.push_back(inst_addr);
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_in(input bit en, input logic [31:0] a, input bit fl, input bit al, input bit inv);
        inst_en     = en;
        inst_addr   = a;
        flush       = fl;
        cmp_allowin = al;
        inv_all     = inv;
    endtask

    typedef struct {
        bit          en;
        logic [31:0] addr;
        bit          fl;
        bit          al;
        bit          ready;
        logic [3:0]  rden;
        bit          valid;
        logic [31:0] baddr;
        logic [3:0]  bmask;
    } vec_t;

    vec_t tbl[10];
    int   bcount;

    initial begin
        tbl[0] = '{1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 32'h0, 4'h0};
        tbl[1] = '{1'b1, 32'h8000_0400, 1'b0, 1'b1, 1'b1, 4'b0101, 1'b1, 32'h8000_0000, 4'b0101};
        tbl[2] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 32'h8000_0400, 4'b1010};
        tbl[3] = '{1'b1, 32'h8000_0010, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 32'h8000_0400, 4'b1010};
        tbl[4] = '{1'b1, 32'h8000_0020, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 32'h8000_0400, 4'b1010};
        tbl[5] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 32'h0, 4'h0};
        tbl[6] = '{1'b1, 32'h8000_07F0, 1'b0, 1'b0, 1'b1, 4'b0101, 1'b0, 32'h0, 4'h0};
        tbl[7] = '{1'b1, 32'h1234_0000, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 32'h8000_07F0, 4'b1010};
        tbl[8] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 32'h8000_07F0, 4'b1010};
        tbl[9] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 32'h0, 4'h0};

        // Clock/reset
        rst_n = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        en4   = 1'b0;
        addr4 = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(1));
        check("rst_rden", 64'(rden), 64'hF);
        check("rst_inv_we", 64'(inv_we), 64'h0);
        check("rst_valid", 64'(rs_to_cs_valid), 64'(0));
        check("rst_ready", 64'(inst_ready), 64'(0));
        check("rst4_inv_we", 64'(inv4), 64'h0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_left  = 128;
        m_drain = 1'b0;

        // Power-up sweep; the one-group instance sweeps 64 sets clearing all four ways.
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            model_step();
            check("v4_busy", 64'(busy4), 64'(i < 64));
            check("v4_inv_we", 64'(inv4), (i < 64) ? 64'hF : 64'h0);
            @(posedge clk);
            #1;
        end

        en4   = 1'b1;
        addr4 = 32'h0000_0150;
        @(negedge clk);
        model_step();
        check("v4_accept_rden", 64'(rden4), 64'h0);
        check("v4_accept_raddr", 64'(raddr4), 64'h15);
        @(posedge clk);
        #1;
        en4 = 1'b0;
        @(negedge clk);
        model_step();
        check("v4_idle_rden", 64'(rden4), 64'hF);
        check("v4_valid", 64'(valid4), 64'(1));
        check("v4_bus", 64'(bus4), 64'({32'h0000_0150, 4'hF}));
        @(posedge clk);
        #1;

        // Table vectors: issue masks, handoff, stall and flush
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].en, tbl[i].addr, tbl[i].fl, tbl[i].al, 1'b0);
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), 64'(inst_ready), 64'(tbl[i].ready));
            check($sformatf("tbl%0d_rden", i), 64'(rden), 64'(tbl[i].rden));
            check($sformatf("tbl%0d_valid", i), 64'(rs_to_cs_valid), 64'(tbl[i].valid));
            if (tbl[i].valid)
                check($sformatf("tbl%0d_bus", i), 64'(rs_to_cs_bus), 64'({tbl[i].baddr, tbl[i].bmask}));
            model_step();
            @(posedge clk);
            #1;
        end

        // Back-to-back accepts with the compare stage always ready
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, $urandom & 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b0);
            cycle();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle();

        // Held request stalled for five cycles, then released
        set_in(1'b1, 32'h4000_0440, 1'b0, 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        run(2);

        // inv_all with a stalled request: drain, handoff, sweep; second inv_all mid-sweep
        set_in(1'b1, 32'h2000_0000, 1'b0, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        run(3);
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        bcount = 0;
        for (int i = 0; i < 140; i++) begin
            inv_all = (i == 50);
            inst_en = (i % 3 == 0);
            @(negedge clk);
            if (busy) bcount++;
            model_step();
            @(posedge clk);
            #1;
        end
        check("drain_sweep_len", 64'(bcount), 64'(128));

        // flush together with inv_all while holding a request goes straight to the sweep
        set_in(1'b1, 32'h1000_0400, 1'b0, 1'b0, 1'b0);
        cycle();
        set_in(1'b1, 32'h1000_0800, 1'b1, 1'b0, 1'b1);
        cycle();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        run(130);

        // Reset in the middle of a sweep restarts it from the first set
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        run(20);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'(1));
        check("midrst_inv_we", 64'(inv_we), 64'h0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_left  = 128;
        m_drain = 1'b0;
        exp_q.delete();
        run(130);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            set_in(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
